// File: rtl/add_serial_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : add_serial_arb                                                |
// | Purpose  : Round-robin arbiter that time-shares one LSB-first bit-serial |
// |            ripple adder among NREQ requesters. The winner's operands are |
// |            latched at grant, added over WIDTH cycles, and the sum/carry  |
// |            are returned with a one-cycle one-hot done pulse.             |
// | Ports    : clk    - rising-edge clock                                    |
// |            rst    - asynchronous active-high reset                       |
// |            req    - per-requester level request, held until done        |
// |            op_a   - flattened operand A, slice i*WIDTH +: WIDTH          |
// |            op_b   - flattened operand B, same slicing                    |
// |            grant  - one-hot owner of the adder                           |
// |            done   - one-hot, one-cycle result-valid pulse                |
// |            busy   - high while in ADD or DONE                            |
// |            result - sum of the last completed add                        |
// |            cout   - carry-out of the last completed add                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module add_serial_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [WIDTH-1:0]        result,
  output logic                    cout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q,  state_d;
  logic [NREQ-1:0]   grant_q,  grant_d;
  logic [NREQ-1:0]   done_q,   done_d;
  logic              busy_q,   busy_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q,   cout_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              carry_q,  carry_d;
  logic [WIDTH-1:0]  a_sh_q,   a_sh_d;
  logic [WIDTH-1:0]  b_sh_q,   b_sh_d;
  logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
  logic [IW-1:0]     last_q,   last_d;
  logic [IW-1:0]     win_q,    win_d;

  // Round-robin winner search
  logic              rr_found;
  logic [IW-1:0]     rr_idx;
  logic [IW:0]       rr_cand;
  int                rr_base;

  // Serial adder bit slice
  logic              sum_bit;
  logic              carry_nxt;

  // Scan starts one past the last winner and wraps, so the most recent
  // owner is considered last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      rr_cand = {1'b0, last_q} + (IW+1)'(i);
      if (rr_cand >= (IW+1)'(NREQ)) begin
        rr_cand = rr_cand - (IW+1)'(NREQ);
      end
      if (!rr_found && req[rr_cand[IW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand[IW-1:0];
      end
    end
    rr_base = int'(rr_idx) * WIDTH;
  end

  always_comb begin
    sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    busy_d   = busy_q;
    result_d = result_q;
    cout_d   = cout_q;
    count_d  = count_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    last_d   = last_q;
    win_d    = win_q;

    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (rr_found) begin
          a_sh_d   = op_a[rr_base +: WIDTH];
          b_sh_d   = op_b[rr_base +: WIDTH];
          sum_sh_d = '0;
          carry_d  = 1'b0;
          count_d  = '0;
          grant_d  = {{(NREQ-1){1'b0}}, 1'b1} << rr_idx;
          win_d    = rr_idx;
          busy_d   = 1'b1;
          state_d  = S_ADD;
        end
      end

      S_ADD: begin
        carry_d  = carry_nxt;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = {sum_bit, sum_sh_q[WIDTH-1:1]};
        count_d  = count_q + CW'(1);
        // Last bit: capture the completed sum so it is valid alongside done.
        if (count_q == CW'(WIDTH-1)) begin
          result_d = sum_sh_d;
          cout_d   = carry_nxt;
          done_d   = grant_q;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        last_d  = win_q;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      last_q   <= IW'(NREQ-1);
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      last_q   <= last_d;
      win_q    <= win_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_add_serial_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_add_serial_arb                                             |
// | Purpose  : Scoreboard bench for add_serial_arb (NREQ=4, WIDTH=8).        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_add_serial_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  result;
  logic        cout;

  add_serial_arb #(.NREQ(4), .WIDTH(8), .CW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op_a   (op_a),
    .op_b   (op_b),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] res;
    logic       co;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] alt_grants [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int i, input logic [7:0] r, input logic c);
    exp_t e;
    e.idx = i; e.res = r; e.co = c;
    sb.push_back(e);
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    op_a[i*8 +: 8] = a;
    op_b[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // One requester alone: grant after the accept edge, done 9 edges later.
  // drop_at > 0 withdraws req after that many edges.
  task automatic single(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] r, input logic c, input int drop_at);
    int  n;
    bit  seen;
    n = 0; seen = 0;
    set_ops(i, a, b);
    push_exp(i, r, c);
    req[i] = 1'b1;
    while (n < 40 && !seen) begin
      tick();
      n++;
      if (n == 1) check("grant_cycle1", {28'd0, grant}, 32'(4'b0001 << i));
      if (n == drop_at) req[i] = 1'b0;
      if (done != 4'd0) begin
        seen = 1;
        check("done_latency", n, 9);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    req[i] = 1'b0;
    repeat (3) tick();
    check("idle_grant", {28'd0, grant}, 0);
    check("idle_busy", {31'd0, busy}, 0);
    check("result_hold", {24'd0, result}, {24'd0, r});
  endtask

  // Scoreboard monitor plus grant/done invariants.
  always @(negedge clk) begin
    if (!rst) begin
      check("grant_onehot0", {31'd0, ((grant & (grant - 4'd1)) != 4'd0)}, 0);
      check("done_subset", {28'd0, done & ~grant}, 0);
      if (done != 4'd0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {28'd0, done}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_onehot", {28'd0, done}, 32'(4'b0001 << e.idx));
          check("result", {24'd0, result}, {24'd0, e.res});
          check("cout", {31'd0, cout}, {31'd0, e.co});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nd, last_t, k;
    logic [3:0] prev_g;

    // Reset state
    do_reset();
    check("rst_grant",  {28'd0, grant},  0);
    check("rst_done",   {28'd0, done},   0);
    check("rst_busy",   {31'd0, busy},   0);
    check("rst_result", {24'd0, result}, 0);
    check("rst_cout",   {31'd0, cout},   0);

    // Basic add and overflow add
    single(0, 8'h5A, 8'h3C, 8'h96, 1'b0, 0);
    single(2, 8'hFF, 8'h01, 8'h00, 1'b1, 0);

    // All four at once from reset: served 0,1,2,3, 10 cycles apart
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_ops(i, 8'(i), 8'h10);
      push_exp(i, 8'(8'h10 + i), 1'b0);
    end
    req = 4'hF;
    n = 0; nd = 0; last_t = 0;
    while (n < 100 && nd < 4) begin
      tick();
      n++;
      if (done != 4'd0) begin
        req = req & ~done;
        if (nd == 0) check("first_done", n, 9);
        else         check("done_spacing", n - last_t, 10);
        last_t = n;
        nd++;
      end
    end
    if (nd < 4) check("all4_timeout", nd, 4);
    req = '0;
    repeat (3) tick();

    // req0 and req2 held: grants alternate 0,2,0,2
    do_reset();
    set_ops(0, 8'h01, 8'h02);
    set_ops(2, 8'h30, 8'h40);
    push_exp(0, 8'h03, 1'b0);
    push_exp(2, 8'h70, 1'b0);
    push_exp(0, 8'h03, 1'b0);
    push_exp(2, 8'h70, 1'b0);
    req = 4'b0101;
    n = 0; nd = 0; k = 0; prev_g = '0;
    while (n < 100 && nd < 4) begin
      tick();
      n++;
      if (grant != 4'd0 && prev_g == 4'd0 && k < 4) begin
        check("alt_grant", {28'd0, grant}, {28'd0, alt_grants[k]});
        k++;
      end
      prev_g = grant;
      if (done != 4'd0) nd++;
    end
    if (nd < 4) check("alt_timeout", nd, 4);
    req = '0;
    repeat (3) tick();
    check("alt_idle_grant", {28'd0, grant}, 0);

    // Reset in the middle of an add: no done, outputs cleared at once
    do_reset();
    set_ops(0, 8'h11, 8'h22);
    req = 4'b0001;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_grant",  {28'd0, grant},  0);
    check("midrst_done",   {28'd0, done},   0);
    check("midrst_busy",   {31'd0, busy},   0);
    check("midrst_result", {24'd0, result}, 0);
    check("midrst_cout",   {31'd0, cout},   0);
    req = '0;
    repeat (2) tick();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done != 4'd0) nd++;
    end
    check("midrst_no_done", nd, 0);
    single(1, 8'h0F, 8'h01, 8'h10, 1'b0, 0);

    // req3 withdrawn during its add: done still pulses
    single(3, 8'h80, 8'h80, 8'h00, 1'b1, 3);

    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
